// File: rtl/gray_pkg.sv
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared Gray-code helpers: binary-to-Gray encode and terminal values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

   localparam int unsigned GRAY_DEFAULT_SIZE = 4;
   // Widest code the helpers handle; callers zero-extend into this width.
   localparam int unsigned GRAY_MAX_SIZE     = 32;

   function automatic logic [GRAY_MAX_SIZE-1:0] bin2gray(input logic [GRAY_MAX_SIZE-1:0] x);
      return x ^ (x >> 1);
   endfunction

   // All-ones of width w when counting up, zero when counting down.
   function automatic logic [GRAY_MAX_SIZE-1:0] terminal_value(input logic up,
                                                               input int unsigned w);
      logic [GRAY_MAX_SIZE-1:0] ones;
      ones = '1;
      return up ? (ones >> (GRAY_MAX_SIZE - w)) : '0;
   endfunction

   function automatic logic is_terminal(input logic [GRAY_MAX_SIZE-1:0] x,
                                        input logic up,
                                        input int unsigned w);
      return x == terminal_value(up, w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/binary_to_gray.sv
// ============================================================================
// Module   : binary_to_gray
// Purpose  : Purely combinational reflected-binary (Gray) encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_gray
   import gray_pkg::*;
#(
   parameter int unsigned DATA_SIZE = GRAY_DEFAULT_SIZE
) (
   input  logic [DATA_SIZE-1:0] b_in,
   output logic [DATA_SIZE-1:0] g_out
);

   logic [GRAY_MAX_SIZE-1:0] bin_ext;
   logic [GRAY_MAX_SIZE-1:0] gray_ext;

   // Zero upper bits leave the MSB passing through unchanged.
   always_comb begin
      bin_ext                = '0;
      bin_ext[DATA_SIZE-1:0] = b_in;
   end

   assign gray_ext = bin2gray(bin_ext);
   assign g_out    = gray_ext[DATA_SIZE-1:0];

endmodule

`default_nettype wire

// File: rtl/gray_code_counter.sv
// ============================================================================
// Module   : gray_code_counter
// Purpose  : Up/down binary counter with registered binary and Gray outputs.
//            Define GRAY_COUNTER_SATURATE_EN to hold at the terminal value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_code_counter
   import gray_pkg::*;
#(
   parameter int unsigned DATA_SIZE = GRAY_DEFAULT_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 up_dn,
   input  logic                 load,
   input  logic [DATA_SIZE-1:0] b_in,
   output logic [DATA_SIZE-1:0] b_out,
   output logic [DATA_SIZE-1:0] g_out,
   output logic                 term
);

   logic [DATA_SIZE-1:0]     bin_q,  bin_d;
   logic [DATA_SIZE-1:0]     gray_q, gray_d;
   logic                     term_q, term_d;
   logic [GRAY_MAX_SIZE-1:0] bin_ext;
   logic                     at_term;

   always_comb begin
      bin_ext                = '0;
      bin_ext[DATA_SIZE-1:0] = bin_q;
   end

   assign at_term = is_terminal(bin_ext, up_dn, DATA_SIZE);

   always_comb begin
      bin_d  = bin_q;
      term_d = 1'b0;
      if (load) begin
         bin_d = b_in;
      end else if (en) begin
         term_d = at_term;
`ifdef GRAY_COUNTER_SATURATE_EN
         if (!at_term)
`endif
            bin_d = up_dn ? (bin_q + 1'b1) : (bin_q - 1'b1);
      end
   end

   // Gray is encoded from the next state so g_out is a clean flop output.
   binary_to_gray #(
      .DATA_SIZE (DATA_SIZE)
   ) u_binary_to_gray (
      .b_in  (bin_d),
      .g_out (gray_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_q  <= '0;
         gray_q <= '0;
         term_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         term_q <= term_d;
      end
   end

   assign b_out = bin_q;
   assign g_out = gray_q;
   assign term  = term_q;

endmodule

`default_nettype wire
